grf_mp: RTL and testbench

Parametrised multi-port general register file for the pipelined CPU: NR combinational read ports, NW synchronous write ports, an optional hardwired zero register, and a per-register busy scoreboard for hazard detection. It replaces the single-write, two-read register file in the decode/writeback stages. It supports a future dual-issue datapath and lets stall logic query pending producers directly.

---
 rtl/grf_mp_pkg.sv | 13 +
 rtl/grf_mp_if.sv | 34 +++
 rtl/grf_wr_arb.sv | 33 +++
 rtl/grf_mp.sv | 95 +++++++++
 tb/tb_grf_mp.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/grf_mp_pkg.sv
// Shared CPU package: register-file geometry constants and the word and
// register-index types used across the decode/writeback datapath.
package cpu_pkg;

    localparam int REG_W     = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;
    localparam int ZERO_ADDR = 0;

    typedef logic [REG_W-1:0]  word_t;
    typedef logic [REG_AW-1:0] ridx_t;

endpackage

// File: rtl/grf_mp_if.sv
// Register-file access bus: write ports, read ports and the busy scoreboard.
// The master drives addresses, data and scoreboard sets. The slave (the
// register file) returns read data, per-port busy bits and the full
// scoreboard.
interface grf_mp_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int DEPTH  = REG_DEPTH,
    parameter int NR     = 2,
    parameter int NW     = 1
) ();
    localparam int AW = $clog2(DEPTH);

    logic [NW-1:0]        we;
    logic [NW*AW-1:0]     waddr;
    logic [NW*DATA_W-1:0] wdata;
    logic [NR*AW-1:0]     raddr;
    logic [NR*DATA_W-1:0] rdata;
    logic [NR-1:0]        rbusy;
    logic                 bset;
    logic [AW-1:0]        bset_addr;
    logic [DEPTH-1:0]     busy_vec;

    modport master (
        output we, waddr, wdata, raddr, bset, bset_addr,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  we, waddr, wdata, raddr, bset, bset_addr,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/grf_wr_arb.sv
// Write-port arbiter: folds NW write ports into a per-register write enable
// and write data. When several ports target one register, the
// highest-indexed port wins. The same result feeds both the register update
// and the read bypass.
module grf_wr_arb
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int DEPTH  = REG_DEPTH,
    parameter int NW     = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic [NW-1:0]        we_i,
    input  logic [NW*AW-1:0]     waddr_i,
    input  logic [NW*DATA_W-1:0] wdata_i,
    output logic [DEPTH-1:0]     wen_o,
    output logic [DATA_W-1:0]    wdat_o [DEPTH]
);

    // Priority select: later (higher-indexed) ports overwrite earlier ones.
    always_comb begin
        wen_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wdat_o[i] = '0;
        end
        for (int k = 0; k < NW; k++) begin
            wen_o[waddr_i[k*AW +: AW]]  = wen_o[waddr_i[k*AW +: AW]] | we_i[k];
            wdat_o[waddr_i[k*AW +: AW]] = we_i[k] ? wdata_i[k*DATA_W +: DATA_W]
                                                  : wdat_o[waddr_i[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with a busy scoreboard. It has NR
// combinational read ports and NW synchronous write ports. An optional
// hardwired zero register is controlled by ZERO_REG.
// Optional write-to-read forwarding is enabled by defining GRF_BYPASS_EN.
module grf_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int DEPTH    = REG_DEPTH,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    grf_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0]     wr_en;
    logic [DATA_W-1:0]    wr_data [DEPTH];
    logic [DATA_W-1:0]    regs_q  [DEPTH];
    logic [DATA_W-1:0]    regs_d  [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [AW-1:0]        rd_addr [NR];
    logic [NR*DATA_W-1:0] rdata_c;
    logic [NR-1:0]        rbusy_c;

    grf_wr_arb #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NW     (NW)
    ) u_wr_arb (
        .we_i    (bus.we),
        .waddr_i (bus.waddr),
        .wdata_i (bus.wdata),
        .wen_o   (wr_en),
        .wdat_o  (wr_data)
    );

    for (genvar j = 0; j < NR; j++) begin : g_rd_addr
        assign rd_addr[j] = bus.raddr[j*AW +: AW];
    end

    // Next state: writes update data and retire busy bits. A new producer
    // (bset) is applied after the clear, so set wins over clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = wr_en[i] ? wr_data[i] : regs_q[i];
            busy_d[i] = busy_q[i] & ~wr_en[i];
        end
        busy_d[bus.bset_addr] = busy_d[bus.bset_addr] | bus.bset;
        regs_d[ZERO_ADDR]     = (ZERO_REG != 0) ? '0   : regs_d[ZERO_ADDR];
        busy_d[ZERO_ADDR]     = (ZERO_REG != 0) ? 1'b0 : busy_d[ZERO_ADDR];
    end

    // Register and scoreboard state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: registered contents, optionally forwarded from this
    // cycle's writes. The zero register always reads 0.
    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int j = 0; j < NR; j++) begin
`ifdef GRF_BYPASS_EN
            rdata_c[j*DATA_W +: DATA_W] = wr_en[rd_addr[j]] ? wr_data[rd_addr[j]]
                                                            : regs_q[rd_addr[j]];
            rbusy_c[j] = busy_q[rd_addr[j]] &
                         ~(wr_en[rd_addr[j]] & ~(bus.bset & (bus.bset_addr == rd_addr[j])));
`else
            rdata_c[j*DATA_W +: DATA_W] = regs_q[rd_addr[j]];
            rbusy_c[j] = busy_q[rd_addr[j]];
`endif
            rdata_c[j*DATA_W +: DATA_W] =
                ((ZERO_REG != 0) && (rd_addr[j] == AW'(ZERO_ADDR))) ? '0
                                                                    : rdata_c[j*DATA_W +: DATA_W];
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rbusy    = rbusy_c;
    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp (NR=2, NW=2): directed scenarios followed
// by randomized traffic compared against an array-based reference model.
module tb_grf_mp;
    import cpu_pkg::*;

    localparam int DATA_W   = REG_W;
    localparam int DEPTH    = REG_DEPTH;
    localparam int NR       = 2;
    localparam int NW       = 2;
    localparam int AW       = REG_AW;
    localparam int ZERO_REG = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    grf_mp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus ();

    grf_mp #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    word_t m_reg  [DEPTH];
    bit    m_busy [DEPTH];
    bit    model_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected read value from the register array plus (optionally) forwarding.
    function automatic word_t exp_rdata(int a);
        word_t v;
        v = m_reg[a];
`ifdef GRF_BYPASS_EN
        for (int k = 0; k < NW; k++)
            if (bus.we[k] && int'(bus.waddr[k*AW +: AW]) == a) v = bus.wdata[k*DATA_W +: DATA_W];
`endif
        if (ZERO_REG != 0 && a == 0) v = '0;
        return v;
    endfunction

    function automatic bit exp_rbusy(int a);
        bit b;
        b = m_busy[a];
`ifdef GRF_BYPASS_EN
        for (int k = 0; k < NW; k++)
            if (bus.we[k] && int'(bus.waddr[k*AW +: AW]) == a &&
                !(bus.bset && int'(bus.bset_addr) == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic check_outputs();
        logic [DEPTH-1:0] ev;
        for (int j = 0; j < NR; j++) begin
            int a;
            a = int'(bus.raddr[j*AW +: AW]);
            check_eq($sformatf("rdata%0d@%0d", j, a), 64'(bus.rdata[j*DATA_W +: DATA_W]), 64'(exp_rdata(a)));
            check_eq($sformatf("rbusy%0d@%0d", j, a), 64'(bus.rbusy[j]), 64'(exp_rbusy(a)));
        end
        for (int i = 0; i < DEPTH; i++) ev[i] = m_busy[i];
        check_eq("busy_vec", 64'(bus.busy_vec), 64'(ev));
    endtask

    // Apply the edge's effect to the model: writes in port order (last wins),
    // clears before sets, zero register immune.
    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            for (int k = 0; k < NW; k++) begin
                int a;
                a = int'(bus.waddr[k*AW +: AW]);
                if (bus.we[k]) begin
                    m_busy[a] = 1'b0;
                    if (!(ZERO_REG != 0 && a == 0)) m_reg[a] = bus.wdata[k*DATA_W +: DATA_W];
                end
            end
            if (bus.bset && !(ZERO_REG != 0 && bus.bset_addr == '0)) m_busy[int'(bus.bset_addr)] = 1'b1;
        end
    endtask

    task automatic tick();
        #1;
        if (model_valid) check_outputs();
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we = '0; bus.waddr = '0; bus.wdata = '0;
        bus.bset = 1'b0; bus.bset_addr = '0;
    endtask

    task automatic wr(input int k, input int a, input word_t d);
        bus.we[k] = 1'b1;
        bus.waddr[k*AW +: AW] = AW'(a);
        bus.wdata[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic rd(input int a0, input int a1);
        bus.raddr[0 +: AW]  = AW'(a0);
        bus.raddr[AW +: AW] = AW'(a1);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd(5, 5);
        wr(0, 5, 32'hDEADBEEF);
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        check_eq("reset_rdata5", 64'(bus.rdata[0 +: DATA_W]), 64'h0);
        check_eq("reset_busy_vec", 64'(bus.busy_vec), 64'h0);

        // Basic write then read on both ports.
        wr(0, 3, 32'h12345678);
        tick();
        idle();
        rd(3, 3);
        #1;
        check_eq("basic_rd0", 64'(bus.rdata[0 +: DATA_W]), 64'h12345678);
        check_eq("basic_rd1", 64'(bus.rdata[DATA_W +: DATA_W]), 64'h12345678);

        // Zero register ignores writes and busy sets.
        wr(0, 0, 32'hFFFFFFFF);
        bus.bset = 1'b1; bus.bset_addr = '0;
        tick();
        idle();
        rd(0, 0);
        #1;
        check_eq("zero_rdata", 64'(bus.rdata[0 +: DATA_W]), 64'h0);
        check_eq("zero_busy", 64'(bus.busy_vec[0]), 64'h0);

        // Same-address conflict: port 1 wins.
        wr(0, 7, 32'h1);
        wr(1, 7, 32'h2);
        tick();
        idle();
        rd(7, 7);
        #1;
        check_eq("conflict_rd", 64'(bus.rdata[0 +: DATA_W]), 64'h2);

        // Scoreboard: set, set-wins-over-clear, clear.
        bus.bset = 1'b1; bus.bset_addr = AW'(9);
        tick();
        idle();
        rd(9, 9);
        #1;
        check_eq("sb_set_vec", 64'(bus.busy_vec[9]), 64'h1);
        check_eq("sb_set_rbusy", 64'(bus.rbusy[0]), 64'h1);
        wr(0, 9, 32'h99);
        bus.bset = 1'b1; bus.bset_addr = AW'(9);
        tick();
        idle();
        #1;
        check_eq("sb_set_wins", 64'(bus.busy_vec[9]), 64'h1);
        wr(0, 9, 32'h9A);
        tick();
        idle();
        #1;
        check_eq("sb_clear", 64'(bus.busy_vec[9]), 64'h0);

        // Same-cycle write/read of register 4.
        wr(0, 4, 32'h11);
        tick();
        idle();
        wr(0, 4, 32'hCAFE0000);
        rd(4, 4);
        #1;
`ifdef GRF_BYPASS_EN
        check_eq("bypass_same_cycle", 64'(bus.rdata[0 +: DATA_W]), 64'hCAFE0000);
`else
        check_eq("bypass_same_cycle", 64'(bus.rdata[0 +: DATA_W]), 64'h11);
`endif
        tick();
        idle();
        #1;
        check_eq("bypass_next_cycle", 64'(bus.rdata[0 +: DATA_W]), 64'hCAFE0000);

        // Randomized traffic over a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < NW; k++) begin
                bus.we[k] = ($urandom_range(0, 2) != 0);
                bus.waddr[k*AW +: AW] = AW'($urandom_range(0, 11));
                bus.wdata[k*DATA_W +: DATA_W] = $urandom;
            end
            bus.bset = ($urandom_range(0, 1) == 1);
            bus.bset_addr = AW'($urandom_range(0, 11));
            rd($urandom_range(0, 11), $urandom_range(0, 31));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
